// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//  Shares the single register-file write port between N_REQ writeback sources.
//  Each source has a one-entry holding buffer behind a valid/ready handshake;
//  a round-robin arbiter moves one buffered write per cycle into a registered
//  output stage that drives the regfile write decoder and data.
//  Writes to $zero are consumed without raising wb_ena.
//  Optional feature macro: WB_BYPASS_EN adds the rd_addr/rd_hit/rd_data
//  forwarding ports, which look up the output stage and buffers.
module regfile_wb_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      wb_ena,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic [DATA_W-1:0]         wb_data,
   output logic [31:0]               pend_mask
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic                      rd_hit,
   output logic [DATA_W-1:0]         rd_data
`endif
);

   localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  buf_valid;
   logic [ADDR_W-1:0] buf_addr [N_REQ];
   logic [DATA_W-1:0] buf_data [N_REQ];
   logic [RR_W-1:0]   rr_ptr;

   logic [N_REQ-1:0]  grant;
   logic [RR_W-1:0]   grant_idx;
   logic              grant_any;

   // Round-robin search over the registered buffers, starting at rr_ptr and wrapping
   always_comb begin
      int idx;
      grant_any = 1'b0;
      grant_idx = '0;
      grant     = '0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!grant_any && buf_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = RR_W'(idx);
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   // A buffer can accept when empty or when it is being drained this cycle
   always_comb begin
      req_ready = ~buf_valid | grant;
   end

   // Holding buffers: a load wins over a drain so back-to-back writes stream through
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            buf_addr[i] <= '0;
            buf_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               buf_valid[i] <= 1'b1;
               buf_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
               buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Output stage and pointer advance; a $zero write updates addr/data but never strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= '0;
         wb_ena  <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else if (grant_any) begin
         wb_ena  <= (buf_addr[grant_idx] != '0);
         wb_addr <= buf_addr[grant_idx];
         wb_data <= buf_data[grant_idx];
         if (grant_idx == RR_W'(N_REQ - 1)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= grant_idx + RR_W'(1);
         end
      end else begin
         wb_ena <= 1'b0;
      end
   end

   // Registers with a write still in flight, for the hazard unit; $zero never pends
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (buf_valid[i]) begin
            pend_mask[buf_addr[i]] = 1'b1;
         end
      end
      if (wb_ena) begin
         pend_mask[wb_addr] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

`ifdef WB_BYPASS_EN
   // Forwarding lookup: output stage is newest, otherwise lowest-index matching buffer
   always_comb begin
      rd_hit  = 1'b0;
      rd_data = '0;
      if (rd_addr != '0) begin
         for (int i = N_REQ - 1; i >= 0; i--) begin
            if (buf_valid[i] && (buf_addr[i] == rd_addr)) begin
               rd_hit  = 1'b1;
               rd_data = buf_data[i];
            end
         end
         if (wb_ena && (wb_addr == rd_addr)) begin
            rd_hit  = 1'b1;
            rd_data = wb_data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//  Directed bench for regfile_wb_arbiter (N_REQ=3). Inputs change and outputs
//  are sampled 1ns after each rising edge. Bypass checks compile only when
//  WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        wb_ena;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] pend_mask;
`ifdef WB_BYPASS_EN
   logic [4:0]  rd_addr;
   logic        rd_hit;
   logic [31:0] rd_data;
`endif

   int checks;
   int failures;

   regfile_wb_arbiter #(.N_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wb_ena    (wb_ena),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .pend_mask (pend_mask)
`ifdef WB_BYPASS_EN
      ,
      .rd_addr   (rd_addr),
      .rd_hit    (rd_hit),
      .rd_data   (rd_data)
`endif
   );

   // 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] v,
                                input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] a2, input logic [31:0] d2);
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
      rd_addr = 5'd0;
`endif
      #12 rst_n = 1'b1;
      tick();

      $display("[TB] reset state");
      checkOutput("rst_ready", 32'(req_ready), 32'h7);
      checkOutput("rst_wb_ena", 32'(wb_ena), 32'h0);
      checkOutput("rst_wb_addr", 32'(wb_addr), 32'h0);
      checkOutput("rst_wb_data", wb_data, 32'h0);
      checkOutput("rst_pend", pend_mask, 32'h0);

      $display("[TB] single write");
      applyStimulus(3'b001, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
      checkOutput("sw_buf_ena", 32'(wb_ena), 32'h0);
      checkOutput("sw_buf_pend", pend_mask, 32'h0000_0020);
      checkOutput("sw_buf_ready", 32'(req_ready), 32'h7);
      tick();
      checkOutput("sw_ena", 32'(wb_ena), 32'h1);
      checkOutput("sw_addr", 32'(wb_addr), 32'd5);
      checkOutput("sw_data", wb_data, 32'hDEADBEEF);
      checkOutput("sw_out_pend", pend_mask, 32'h0000_0020);
      tick();
      checkOutput("sw_ena_drop", 32'(wb_ena), 32'h0);
      checkOutput("sw_pend_clear", pend_mask, 32'h0);
      checkOutput("sw_addr_hold", 32'(wb_addr), 32'd5);

      $display("[TB] zero register");
      applyStimulus(3'b010, 5'd0, 32'h0, 5'd0, 32'h5555AAAA, 5'd0, 32'h0);
      tick();
      applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
      checkOutput("z_buf_ready", 32'(req_ready), 32'h7);
      checkOutput("z_buf_pend", pend_mask, 32'h0);
      tick();
      checkOutput("z_ena", 32'(wb_ena), 32'h0);
      checkOutput("z_addr", 32'(wb_addr), 32'd0);
      checkOutput("z_data", wb_data, 32'h5555AAAA);
      checkOutput("z_pend", pend_mask, 32'h0);
      checkOutput("z_ready", 32'(req_ready), 32'h7);

      // req2 write brings the pointer back round to 0
      applyStimulus(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h99);
      tick();
      applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      checkOutput("r2_addr", 32'(wb_addr), 32'd9);
      checkOutput("r2_data", wb_data, 32'h99);
      tick();

      $display("[TB] same target");
      applyStimulus(3'b101, 5'd7, 32'h11, 5'd0, 32'h0, 5'd7, 32'h22);
      tick();
      applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
      checkOutput("st_ready", 32'(req_ready), 32'h3);
      checkOutput("st_pend", pend_mask, 32'h0000_0080);
`ifdef WB_BYPASS_EN
      rd_addr = 5'd7;
`endif
      tick();
      checkOutput("st_first_ena", 32'(wb_ena), 32'h1);
      checkOutput("st_first_data", wb_data, 32'h11);
`ifdef WB_BYPASS_EN
      checkOutput("byp_hit1", 32'(rd_hit), 32'h1);
      checkOutput("byp_data1", rd_data, 32'h11);
`endif
      tick();
      checkOutput("st_second_ena", 32'(wb_ena), 32'h1);
      checkOutput("st_second_addr", 32'(wb_addr), 32'd7);
      checkOutput("st_second_data", wb_data, 32'h22);
`ifdef WB_BYPASS_EN
      checkOutput("byp_hit2", 32'(rd_hit), 32'h1);
      checkOutput("byp_data2", rd_data, 32'h22);
`endif
      tick();
      checkOutput("st_done_ena", 32'(wb_ena), 32'h0);
      checkOutput("st_done_pend", pend_mask, 32'h0);
`ifdef WB_BYPASS_EN
      checkOutput("byp_miss", 32'(rd_hit), 32'h0);
      checkOutput("byp_miss_data", rd_data, 32'h0);
      rd_addr = 5'd0;
`endif

      $display("[TB] contention");
      applyStimulus(3'b111, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd3, 32'hA3);
      tick();
      checkOutput("ct_first_ena", 32'(wb_ena), 32'h0);
      checkOutput("ct_pend", pend_mask, 32'h0000_000E);
      tick();
      checkOutput("ct_e1_ena", 32'(wb_ena), 32'h1);
      checkOutput("ct_e1_addr", 32'(wb_addr), 32'd1);
      tick();
      checkOutput("ct_e2_ena", 32'(wb_ena), 32'h1);
      checkOutput("ct_e2_addr", 32'(wb_addr), 32'd2);
      tick();
      checkOutput("ct_e3_ena", 32'(wb_ena), 32'h1);
      checkOutput("ct_e3_addr", 32'(wb_addr), 32'd3);
      checkOutput("ct_e3_data", wb_data, 32'hA3);
      tick();
      checkOutput("ct_e4_ena", 32'(wb_ena), 32'h1);
      checkOutput("ct_e4_addr", 32'(wb_addr), 32'd1);
      tick();
      checkOutput("ct_e5_ena", 32'(wb_ena), 32'h1);
      checkOutput("ct_e5_addr", 32'(wb_addr), 32'd2);
      checkOutput("ct_e5_pend", pend_mask, 32'h0000_000E);

      $display("[TB] reset mid-stream");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mr_ready", 32'(req_ready), 32'h7);
      checkOutput("mr_ena", 32'(wb_ena), 32'h0);
      checkOutput("mr_pend", pend_mask, 32'h0);
      applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      checkOutput("mr_hold_ena", 32'(wb_ena), 32'h0);
      checkOutput("mr_hold_data", wb_data, 32'h0);
      rst_n = 1'b1;
      tick();
      checkOutput("mr_post_ena", 32'(wb_ena), 32'h0);
      checkOutput("mr_post_pend", pend_mask, 32'h0);

      // the pointer was at 2 before reset; req0 must now win first
      applyStimulus(3'b101, 5'd4, 32'h44, 5'd0, 32'h0, 5'd6, 32'h66);
      tick();
      applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      checkOutput("mr_rr_first", 32'(wb_addr), 32'd4);
      tick();
      checkOutput("mr_rr_second", 32'(wb_addr), 32'd6);
      checkOutput("mr_rr_data", wb_data, 32'h66);
      tick();
      checkOutput("mr_idle_ena", 32'(wb_ena), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
